// File: rtl/pipe_sel_mux_if.sv
// Handshake bundle for pipe_sel_mux: flattened inputs, select, and both valid/ready pairs.
// Latency: none, wires only.
// Backpressure: the slave drives in_ready; the master drives out_ready.
interface pipe_sel_mux_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
);
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;

  // Producer/consumer side (drives inputs, observes outputs)
  modport master (
    output in_data, sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_valid
  );

  // Mux side
  modport slave (
    input  in_data, sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/pipe_sel_mux.sv
// Registered N-to-1 select mux with a transfer counter and optional sticky bad-select flag.
// Latency: 1 cycle from accept to out_valid/out_data; sel >= NUM_IN loads zeros.
// Backpressure: in_ready = (!out_valid || out_ready) && !flush; held data stays stable.
// Optional feature macro: PIPE_SEL_MUX_SEL_ERR_EN builds the sticky sel_err register.
module pipe_sel_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  pipe_sel_mux_if.slave    bus,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic             sel_err
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic [WIDTH-1:0] sel_data;
  logic             sel_oob;
  logic             in_ready;
  logic             accept;

  // Ready only when the output slot is free or draining this cycle; flush blocks new entries.
  always_comb begin
    in_ready = (!out_valid_q || bus.out_ready) && !bus.flush;
    accept   = bus.in_valid && in_ready;
  end

  // Select the indexed input; out-of-range indices yield zeros.
  always_comb begin
    sel_data = '0;
    sel_oob  = (int'(bus.sel) >= NUM_IN);
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(bus.sel) == k) begin
        sel_data = bus.in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state for the output slot and the transfer counter.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    xfer_cnt_d  = xfer_cnt_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      xfer_cnt_d  = xfer_cnt_q + 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset wins over accept and flush.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      xfer_cnt_q  <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

`ifdef PIPE_SEL_MUX_SEL_ERR_EN
  logic sel_err_q, sel_err_d;

  // Sticky flag: any accepted out-of-range select latches it until reset.
  always_comb begin
    sel_err_d = sel_err_q || (accept && sel_oob);
  end

  // Flag register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;
`else
  // Flag disabled: tie off; the out-of-range zero-data behaviour is kept above.
  logic unused_oob;
  assign unused_oob = sel_oob;
  assign sel_err    = 1'b0;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign xfer_cnt      = xfer_cnt_q;

endmodule

// File: tb/tb_pipe_sel_mux.sv
// Directed bench for pipe_sel_mux: a vector table on a 4-input instance, hand sequences on a 3-input/4-bit-counter instance.
// Latency: outputs are checked 1 ns after each rising edge; in_ready is checked after inputs settle.
// Backpressure: stall, flush and consume cases are encoded in the vector table.
module tb_pipe_sel_mux;

  logic Clk = 1'b0;
  logic rst_a, rst_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  logic        err_a, err_b;

  int total = 0;
  int bad   = 0;

`ifdef PIPE_SEL_MUX_SEL_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  always #5 Clk = ~Clk;

  pipe_sel_mux_if #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) ifa ();
  pipe_sel_mux_if #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) ifb ();

  pipe_sel_mux #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .CNT_W(16)) dut_a (
    .Clk(Clk), .Rst(rst_a), .bus(ifa), .xfer_cnt(cnt_a), .sel_err(err_a)
  );

  pipe_sel_mux #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .CNT_W(4)) dut_b (
    .Clk(Clk), .Rst(rst_b), .bus(ifb), .xfer_cnt(cnt_b), .sel_err(err_b)
  );

  typedef struct {
    logic        iv;
    logic [1:0]  sel;
    logic        fl;
    logic        ordy;
    logic        e_rdy;
    logic        e_vld;
    logic [31:0] e_dat;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_b(input logic iv, input logic [1:0] sel, input logic ordy);
    ifb.in_valid  = iv;
    ifb.sel       = sel;
    ifb.out_ready = ordy;
    ifb.flush     = 1'b0;
  endtask

  initial begin
    // iv sel fl ordy | rdy vld dat cnt   (in_data = {4,3,2,1})
    vecs[0]  = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 32'd3, 16'd1}; // first accept
    vecs[1]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd3, 16'd1}; // stall x5
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd3, 16'd1};
    vecs[3]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd3, 16'd1};
    vecs[4]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd3, 16'd1};
    vecs[5]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd3, 16'd1};
    vecs[6]  = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd1, 16'd2}; // release, sel 0
    vecs[7]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd2, 16'd3}; // back-to-back
    vecs[8]  = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 32'd3, 16'd4};
    vecs[9]  = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1, 32'd4, 16'd5};
    vecs[10] = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd4, 16'd5}; // flush held entry
    vecs[11] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd4, 16'd5}; // idle, empty
    vecs[12] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd2, 16'd6}; // accept into empty
    vecs[13] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd2, 16'd6}; // consume, data holds
    vecs[14] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd2, 16'd6};
    vecs[15] = '{1'b1, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 32'd2, 16'd6}; // flush when empty

    ifa.in_data = {32'd4, 32'd3, 32'd2, 32'd1};
    ifa.sel = 2'd0; ifa.in_valid = 1'b1; ifa.flush = 1'b1; ifa.out_ready = 1'b0;
    ifb.in_data = {32'd30, 32'd20, 32'd10};
    drive_b(1'b1, 2'd3, 1'b1);
    rst_a = 1'b1; rst_b = 1'b1;
    step(); step();
    ifa.in_valid = 1'b0; ifa.flush = 1'b0;
    drive_b(1'b0, 2'd0, 1'b0);
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    chk("rst_vld_a", 32'(ifa.out_valid), 32'd0);
    chk("rst_dat_a", ifa.out_data, 32'd0);
    chk("rst_cnt_a", 32'(cnt_a), 32'd0);
    chk("rst_err_a", 32'(err_a), 32'd0);
    chk("rst_rdy_a", 32'(ifa.in_ready), 32'd1);
    chk("rst_err_b", 32'(err_b), 32'd0);

    // Vector table on instance A
    for (int i = 0; i < 16; i++) begin
      ifa.in_valid  = vecs[i].iv;
      ifa.sel       = vecs[i].sel;
      ifa.flush     = vecs[i].fl;
      ifa.out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d_rdy", i), 32'(ifa.in_ready), 32'(vecs[i].e_rdy));
      step();
      chk($sformatf("v%0d_vld", i), 32'(ifa.out_valid), 32'(vecs[i].e_vld));
      chk($sformatf("v%0d_dat", i), ifa.out_data, vecs[i].e_dat);
      chk($sformatf("v%0d_cnt", i), 32'(cnt_a), 32'(vecs[i].e_cnt));
    end
    chk("err_a_inrange", 32'(err_a), 32'd0);

    // Instance B: out-of-range select, sticky flag, counter wrap, reset vs accept
    drive_b(1'b1, 2'd1, 1'b1); step();
    chk("b_sel1_dat", ifb.out_data, 32'd20);
    chk("b_sel1_err", 32'(err_b), 32'd0);
    drive_b(1'b1, 2'd3, 1'b1); step();
    chk("b_oob_dat", ifb.out_data, 32'd0);
    chk("b_oob_vld", 32'(ifb.out_valid), 32'd1);
    chk("b_oob_cnt", 32'(cnt_b), 32'd2);
    chk("b_oob_err", 32'(err_b), 32'(ERR_EXP));
    drive_b(1'b1, 2'd0, 1'b1); step();
    chk("b_sel0_dat", ifb.out_data, 32'd10);
    chk("b_sticky1", 32'(err_b), 32'(ERR_EXP));
    drive_b(1'b0, 2'd0, 1'b1); step(); step();
    chk("b_sticky2", 32'(err_b), 32'(ERR_EXP));
    chk("b_idle_vld", 32'(ifb.out_valid), 32'd0);
    for (int i = 0; i < 14; i++) begin
      drive_b(1'b1, 2'd2, 1'b1); step();
    end
    chk("b_wrap_cnt", 32'(cnt_b), 32'd1);
    chk("b_wrap_dat", ifb.out_data, 32'd30);
    chk("b_sticky3", 32'(err_b), 32'(ERR_EXP));
    // Reset concurrent with an accept
    drive_b(1'b1, 2'd1, 1'b1);
    rst_b = 1'b1; step();
    rst_b = 1'b0;
    drive_b(1'b0, 2'd0, 1'b0); #1;
    chk("b_rst_vld", 32'(ifb.out_valid), 32'd0);
    chk("b_rst_cnt", 32'(cnt_b), 32'd0);
    chk("b_rst_dat", ifb.out_data, 32'd0);
    chk("b_rst_err", 32'(err_b), 32'd0);
    chk("b_rst_rdy", 32'(ifb.in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_sel_mux.md
PIPE_SEL_MUX -- requirements
Module: pipe_sel_mux

Interface
REQ-001 Parameter WIDTH, default 32, the data width of each input and of the output.
REQ-002 Parameter NUM_IN, default 4, the number of selectable inputs (legal range 2..16).
REQ-003 Parameter SEL_W, default 2, the select width (SHALL be ≥ ceil(log2(NUM_IN))).
REQ-004 Parameter CNT_W, default 16, the transfer-counter width.
REQ-005 Clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-006 Rst  input  1  synchronous, active-high reset.
REQ-007 in_data  input  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
REQ-008 sel  input  SEL_W  the input index, sampled on an accepted transfer.
REQ-009 in_valid  input  1  the upstream offers in_data/sel this cycle.
REQ-010 in_ready  output  1  the block accepts an offer this cycle.
REQ-011 flush  input  1  discards the held entry and blocks acceptance this cycle.
REQ-012 out_data  output  WIDTH  the registered selected data.
REQ-013 out_valid  output  1  out_data holds a live entry.
REQ-014 out_ready  input  1  downstream consumes the entry when out_valid=1.
REQ-015 xfer_cnt  output  CNT_W  the count of accepted transfers.
REQ-016 sel_err  output  1  the sticky out-of-range select flag (see Configuration).

Function
REQ-017 in_ready SHALL equal (!out_valid || out_ready) && !flush, combinationally.
REQ-018 An accept SHALL occur when in_valid && in_ready; on accept, out_data SHALL load the selected input at the next edge and out_valid SHALL be 1 (latency 1 cycle).
REQ-019 When sel ≥ NUM_IN on accept, out_data SHALL load all zeros.
REQ-020 Without an accept, out_data SHALL hold its value; out_valid SHALL clear when out_ready=1, otherwise hold.
REQ-021 Simultaneous consume and accept in the same cycle SHALL keep out_valid=1 with the new data, with no bubble.
REQ-022 flush=1 SHALL clear out_valid at the next edge regardless of in_valid/out_ready, with no accept; out_data SHALL hold.
REQ-023 xfer_cnt SHALL increment by 1 on each accept and wrap from 2^CNT_W-1 to 0; flush and stalls SHALL not change it.
REQ-024 While out_valid=1 and out_ready=0, out_data SHALL be stable.

Reset
REQ-025 Rst=1 at an edge SHALL set out_valid=0, out_data=0, xfer_cnt=0 and sel_err=0, overriding accept and flush in the same cycle.
REQ-026 A live entry SHALL be dropped by reset without being presented as consumed; in_ready SHALL be 1 in the first cycle after reset deasserts (flush=0).

Configuration
REQ-027 Macro PIPE_SEL_MUX_SEL_ERR_EN defined: sel_err SHALL set at the edge following an accept with sel ≥ NUM_IN and remain set until Rst.
REQ-028 Macro PIPE_SEL_MUX_SEL_ERR_EN undefined: sel_err SHALL be constant 0 and no flag register SHALL be built; the zero-data behaviour of REQ-019 still applies.

Verification
REQ-029 Reset, then in_data={4,3,2,1}(k=3..0), sel=2, in_valid=1, out_ready=1 for one cycle -> next cycle out_valid=1, out_data=3, xfer_cnt=1.
REQ-030 out_ready=0 with an entry held, new offer sel=0 -> in_ready=0, out_data unchanged for 5 cycles, xfer_cnt unchanged; raising out_ready -> the new entry appears the following cycle.
REQ-031 Back-to-back accepts sel=0,1,2,3 with out_ready=1 -> out_data 1,2,3,4 on consecutive cycles, out_valid continuously 1, xfer_cnt=4.
REQ-032 flush=1 with in_valid=1 and an entry held -> in_ready=0, out_valid=0 next cycle, xfer_cnt unchanged.
REQ-033 NUM_IN=3, sel=3 accepted -> out_data=0; sel_err=1 with the macro, sel_err=0 without it; sel_err stays 1 until Rst.
REQ-034 CNT_W=4, 17 accepts -> xfer_cnt=1; Rst asserted concurrently with an accept -> out_valid=0 and xfer_cnt=0.
